ws2812_chain: RTL and testbench

Parametrised WS2812-style serial LED driver for a daisy chain of NUM_LEDS pixels.
- Holds one colour word per pixel in an internal register buffer, writable by the host at any time.
- On a frame request, serialises all words MSB-first onto one data line with configurable pulse widths, then holds the line low for a latch gap.
- Adds a start/busy/done handshake and an optional free-running refresh mode.
- Sits between host/application logic and the LED data pin of the extension board.

---
 rtl/ws2812_chain.sv | 91 +++++++++
 tb/tb_ws2812_chain.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/ws2812_chain.sv
// ws2812_chain: WS2812-style serial driver for a daisy chain of NUM_LEDS pixels.
// Ports: clk/rst (sync, active high); wr_en/wr_addr/wr_data write the pixel buffer;
// start requests a frame (sampled in IDLE); busy spans frame + latch gap; done
// pulses one cycle at frame end; rgb is the serial line to the first pixel.
module ws2812_chain #(
  parameter int NUM_LEDS = 8,
  parameter int BITS_PER_LED = 24,
  parameter int TICKS_BIT_SHORT = 8,
  parameter int TICKS_BIT_LONG = 32,
  parameter int TICKS_RESET = 9000,
  parameter int AUTO_REFRESH = 0,
  localparam int ADDR_W = NUM_LEDS > 1 ? $clog2(NUM_LEDS) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic [ADDR_W-1:0]       wr_addr,
  input  logic [BITS_PER_LED-1:0] wr_data,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic                    rgb
);
  localparam int BW = BITS_PER_LED > 1 ? $clog2(BITS_PER_LED) : 1;
  localparam int TM = TICKS_RESET > TICKS_BIT_LONG ? TICKS_RESET : TICKS_BIT_LONG;
  localparam int TW = TM > 1 ? $clog2(TM) : 1;
  localparam logic [TW-1:0] S1 = TW'(TICKS_BIT_SHORT - 1);
  localparam logic [TW-1:0] L1 = TW'(TICKS_BIT_LONG - 1);
  localparam logic [TW-1:0] R1 = TW'(TICKS_RESET - 1);
  localparam logic [ADDR_W:0] NL = (ADDR_W + 1)'(NUM_LEDS);
  typedef enum logic [1:0] {IDLE, HIGH, LOW, LATCH} state_t;
  state_t state, state_n;
  logic [TW-1:0] cnt, lim;
  logic [BW-1:0] bidx;
  logic [ADDR_W-1:0] pix, ld_idx;
  logic [BITS_PER_LED-1:0] sh, ld_word;
  logic [BITS_PER_LED-1:0] mem [NUM_LEDS];
  logic cur, last, last_bit, last_pix, go, wr_ok;
  always_comb begin
    cur = sh[BITS_PER_LED-1];
    lim = state == HIGH ? (cur ? L1 : S1) : state == LOW ? (cur ? S1 : L1) : R1;
    last = cnt == lim;
    last_bit = bidx == BW'(BITS_PER_LED - 1);
    last_pix = pix == ADDR_W'(NUM_LEDS - 1);
    go = start || (AUTO_REFRESH != 0);
    wr_ok = wr_en && ({1'b0, wr_addr} < NL);
    ld_idx = state == IDLE ? '0 : pix + 1'b1;
    // a write landing on the same edge as the load is forwarded straight in
    ld_word = (wr_ok && wr_addr == ld_idx) ? wr_data : mem[ld_idx];
    state_n = state;
    case (state)
      IDLE:  state_n = go ? HIGH : IDLE;
      HIGH:  state_n = last ? LOW : HIGH;
      LOW:   state_n = last ? ((last_bit && last_pix) ? LATCH : HIGH) : LOW;
      LATCH: state_n = last ? IDLE : LATCH;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      bidx <= '0;
      pix <= '0;
      sh <= '0;
      done <= 1'b0;
      for (int i = 0; i < NUM_LEDS; i++) mem[i] <= '0;
    end else begin
      state <= state_n;
      done <= state == LATCH && last;
      cnt <= (state == IDLE || state != state_n) ? '0 : cnt + 1'b1;
      if (wr_ok) mem[wr_addr] <= wr_data;
      if (state == IDLE && go) begin
        sh <= ld_word;
        bidx <= '0;
        pix <= '0;
      end else if (state == LOW && last && !(last_bit && last_pix)) begin
        if (!last_bit) begin
          bidx <= bidx + 1'b1;
          sh <= sh << 1;
        end else begin
          bidx <= '0;
          pix <= pix + 1'b1;
          sh <= ld_word;
        end
      end
    end
  end
  assign rgb = state == HIGH;
  assign busy = state != IDLE;
endmodule

// File: tb/tb_ws2812_chain.sv
// tb_ws2812_chain: self-checking bench for ws2812_chain against a waveform model.
module tb_ws2812_chain;
  localparam int FL = 298;
  logic clk = 0, rst = 1, wr_en = 0, start = 0;
  logic [0:0] wr_addr = '0;
  logic [23:0] wr_data = '0;
  logic busy, done, rgb, ar_busy, ar_done, ar_rgb;
  int checks = 0, errors = 0;
  logic [23:0] mdl [2];

  always #5 clk = ~clk;

  ws2812_chain #(.NUM_LEDS(2), .BITS_PER_LED(24), .TICKS_BIT_SHORT(2), .TICKS_BIT_LONG(4),
                 .TICKS_RESET(10), .AUTO_REFRESH(0)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .busy(busy), .done(done), .rgb(rgb));

  ws2812_chain #(.NUM_LEDS(2), .BITS_PER_LED(24), .TICKS_BIT_SHORT(2), .TICKS_BIT_LONG(4),
                 .TICKS_RESET(10), .AUTO_REFRESH(1)) dut_a (
    .clk(clk), .rst(rst), .wr_en(1'b0), .wr_addr(1'b0), .wr_data(24'h0),
    .start(1'b0), .busy(ar_busy), .done(ar_done), .rgb(ar_rgb));

  typedef struct {
    logic [23:0] w0, w1;
    bit pre;
    int wc;
    logic wa;
    logic [23:0] wd;
    int sc;
    int len;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wr(input logic a, input logic [23:0] d);
    @(negedge clk);
    wr_en = 1; wr_addr = a; wr_data = d;
    @(negedge clk);
    wr_en = 0;
    mdl[a] = d;
  endtask

  task automatic run_frame(input vec_t v);
    logic [23:0] e [2];
    logic ex [400];
    int k, bad, hi;
    if (v.pre) begin
      wr(1'b0, v.w0);
      wr(1'b1, v.w1);
    end
    // each pixel is captured at its start edge (pixel p at edge p*144); a write at or before it is seen
    for (int p = 0; p < 2; p++)
      e[p] = (v.wc > 0 && int'(v.wa) == p && v.wc <= p * 144) ? v.wd : mdl[p];
    k = 0;
    for (int p = 0; p < 2; p++)
      for (int b = 23; b >= 0; b--) begin
        hi = e[p][b] ? 4 : 2;
        for (int i = 0; i < 6; i++) ex[k++] = i < hi;
      end
    for (int i = 0; i < 10; i++) ex[k++] = 0;
    @(negedge clk);
    start = 1;
    bad = 0;
    for (int c = 0; c < v.len; c++) begin
      @(negedge clk);
      start = (c + 1 == v.sc);
      wr_en = (c + 1 == v.wc);
      wr_addr = v.wa;
      wr_data = v.wd;
      if (rgb !== ex[c] || busy !== 1'b1 || done !== 1'b0) bad++;
    end
    @(negedge clk);
    wr_en = 0; start = 0;
    chk("frame_wave_bad_cycles", bad, 0);
    chk("end_busy_done", {busy, done}, 2'b01);
    @(negedge clk);
    chk("after_done", {busy, done, rgb}, 3'b000);
    if (v.wc > 0) mdl[v.wa] = v.wd;
  endtask

  initial begin
    vec_t tv [15];
    vec_t z;
    int n, idl, hi, dn;
    tv[0] = '{24'h0, 24'h0, 0, 0, 0, 24'h0, 0, FL};
    tv[1] = '{24'h800000, 24'h000001, 1, 0, 0, 24'h0, 0, FL};
    tv[2] = '{24'h0, 24'h0, 0, 0, 0, 24'h0, 50, FL};
    tv[3] = '{24'h0, 24'h0, 0, 0, 0, 24'h0, 0, FL};
    tv[4] = '{24'h800000, 24'h000001, 1, 20, 1, 24'hFFFFFF, 0, FL};
    tv[5] = '{24'h0, 24'h0, 0, 200, 0, 24'h000000, 0, FL};
    tv[6] = '{24'h0, 24'h0, 0, 0, 0, 24'h0, 0, FL};
    tv[7] = '{24'h0, 24'h0, 0, 144, 1, 24'h123456, 0, FL};
    tv[8] = '{24'h0, 24'h0, 0, 1, 0, 24'hA5A5A5, 0, FL};
    for (int i = 9; i < 15; i++)
      tv[i] = '{24'($urandom), 24'($urandom), 1, int'($urandom_range(0, 297)), 1'($urandom),
                24'($urandom), int'($urandom_range(1, 298)), FL};
    mdl[0] = 0; mdl[1] = 0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {rgb, busy, done}, 3'b000);
    rst = 0;
    for (int i = 0; i < 15; i++) run_frame(tv[i]);
    wr(1'b0, 24'hFFFFFF);
    wr(1'b1, 24'hFFFFFF);
    @(negedge clk);
    start = 1;
    @(negedge clk);
    start = 0;
    repeat (60) @(negedge clk);
    chk("bit10_high", rgb, 1);
    rst = 1;
    @(negedge clk);
    chk("mid_reset_outputs", {rgb, busy, done}, 3'b000);
    rst = 0;
    mdl[0] = 0; mdl[1] = 0;
    dn = 0;
    repeat (3) begin
      @(negedge clk);
      dn += done;
    end
    chk("no_done_after_reset", dn, 0);
    z = '{24'h0, 24'h0, 0, 0, 0, 24'h0, 0, FL};
    run_frame(z);
    rst = 1;
    repeat (2) @(negedge clk);
    rst = 0;
    @(negedge clk);
    for (int f = 0; f < 3; f++) begin
      n = 0; hi = 0; dn = 0;
      while (ar_busy && n < 400) begin
        hi += ar_rgb; dn += ar_done; n++;
        @(negedge clk);
      end
      chk("auto_busy_len", n, FL);
      chk("auto_done_at_fall", ar_done, 1);
      idl = 0;
      while (!ar_busy && idl < 10) begin
        dn += ar_done; idl++;
        @(negedge clk);
      end
      chk("auto_idle_len", idl, 1);
      chk("auto_high_cycles", hi, 96);
      chk("auto_done_count", dn, 1);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
